// File: rtl/keccak_pkg.sv
// Shared Keccak types, the forward chi row function and the inverse chi S-box.
package keccak_pkg;

  localparam int N = 64;

  // Planes are indexed [x][z]. States are indexed [y][x][z].
  typedef logic [4:0][N-1:0]      plane;
  typedef logic [4:0][4:0][N-1:0] state;

  // Inverse of the 5-bit chi row map, indexed by the chi output value.
  localparam logic [4:0] CHI_INV_LUT [32] = '{
    5'd0,  5'd11, 5'd22, 5'd9,  5'd13, 5'd4,  5'd18, 5'd15,
    5'd26, 5'd1,  5'd8,  5'd3,  5'd5,  5'd12, 5'd30, 5'd7,
    5'd21, 5'd20, 5'd2,  5'd23, 5'd16, 5'd17, 5'd6,  5'd19,
    5'd10, 5'd27, 5'd24, 5'd25, 5'd29, 5'd28, 5'd14, 5'd31
  };

  // Forward chi on one row: b[x] = r[x] ^ (~r[x+1] & r[x+2]), indices mod 5.
  function automatic logic [4:0] chi_row(input logic [4:0] r);
    logic [4:0] b;
    for (int x = 0; x < 5; x++)
      b[x] = r[x] ^ (~r[(x + 1) % 5] & r[(x + 2) % 5]);
    return b;
  endfunction

endpackage

// File: rtl/chi_inv_plane.sv
// Combinational inverse chi over one plane: one LUT lookup per z column.
module chi_inv_plane
  import keccak_pkg::*;
(
  input  plane i_plane,
  output plane o_plane
);

  for (genvar z = 0; z < N; z++) begin : g_z
    logic [4:0] w_row;
    logic [4:0] w_inv;
    for (genvar x = 0; x < 5; x++) begin : g_x
      assign w_row[x]       = i_plane[x][z];
      assign o_plane[x][z]  = w_inv[x];
    end
    assign w_inv = CHI_INV_LUT[w_row];
  end

endmodule

// File: rtl/chi_inv_iter.sv
// Iterative inverse chi over a full state, PLANES_PER_CYC planes per clock.
// PLANES_PER_CYC must be 1 or 5 so the plane walk lands exactly on y=4.
module chi_inv_iter
  import keccak_pkg::*;
#(
  parameter int PLANES_PER_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  state A_in,
  output logic out_valid,
  input  logic out_ready,
  output state A_out
);

  // Plane index of the final RUN step; the counter parks here afterwards.
  localparam logic [2:0] LAST_CNT = 3'(5 - PLANES_PER_CYC);
  localparam logic [2:0] STEP     = 3'(PLANES_PER_CYC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e       r_fsm;
  fsm_e       w_fsm_nxt;
  logic [2:0] r_cnt;
  state       r_w;

  plane w_pin  [PLANES_PER_CYC];
  plane w_pout [PLANES_PER_CYC];

  // Plane-select mux feeding the inverters; counter stays <= 4 so no overflow.
  for (genvar p = 0; p < PLANES_PER_CYC; p++) begin : g_plane
    assign w_pin[p] = r_w[r_cnt + 3'(p)];
    chi_inv_plane u_plane (
      .i_plane (w_pin[p]),
      .o_plane (w_pout[p])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next state and handshake outputs; in_ready depends on the state only.
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = RUN;
      end
      RUN:  if (r_cnt == LAST_CNT) w_fsm_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Working state: load on accept, then write inverted planes back in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_fsm)
        IDLE: if (in_valid) begin
          r_w   <= A_in;
          r_cnt <= '0;
        end
        RUN: begin
          for (int p = 0; p < PLANES_PER_CYC; p++)
            r_w[r_cnt + 3'(p)] <= w_pout[p];
          if (r_cnt != LAST_CNT) r_cnt <= r_cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  assign A_out = r_w;

endmodule
